// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: opcodes, ALU function codes, status codes,
// the "no register" id and the field values loaded by a pipeline bubble.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // ALU function select (drives alu S1:S0 directly)
    localparam logic [1:0] ALUADD = 2'd0;
    localparam logic [1:0] ALUSUB = 2'd1;
    localparam logic [1:0] ALUAND = 2'd2;
    localparam logic [1:0] ALUXOR = 2'd3;

    // Status codes
    localparam logic [3:0] SAOK = 4'd1;
    localparam logic [3:0] SHLT = 4'd2;
    localparam logic [3:0] SADR = 4'd3;
    localparam logic [3:0] SINS = 4'd4;

    localparam logic [3:0] RNONE = 4'hF;

    // Bubble field values
    localparam logic [3:0] BUBBLE_STAT  = SAOK;
    localparam logic [3:0] BUBBLE_ICODE = INOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;

    // Control fields of the E pipeline register
    typedef struct packed {
        logic [3:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } e_ctrl_t;

    localparam e_ctrl_t E_CTRL_BUBBLE = '{
        stat:  BUBBLE_STAT,
        icode: BUBBLE_ICODE,
        ifun:  BUBBLE_IFUN,
        dst_e: RNONE,
        dst_m: RNONE
    };

    // True for the status codes that mark an excepting instruction
    function automatic logic stat_is_exc(input logic [3:0] s);
        return (s == SHLT) || (s == SADR) || (s == SINS);
    endfunction

endpackage

// File: rtl/alu.sv
// 64-bit ALU: out = b op a, op selected by s (0 add, 1 sub, 2 and, 3 xor).
// Ports: a, b operands; s function select; out result; ovf signed overflow
// (only meaningful for add/sub, forced 0 for and/xor).
module alu #(
    parameter int W = 64
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic        [1:0]   s,
    output logic signed [W-1:0] out,
    output logic                ovf
);
    import y86_pkg::*;

    logic                is_arith;
    logic                is_sub;
    logic signed [W-1:0] a_op;
    logic signed [W-1:0] sum;
    logic signed [W-1:0] add_gated;
    logic signed [W-1:0] and_gated;
    logic signed [W-1:0] xor_gated;

    assign is_arith = ~s[1];
    assign is_sub   = (s == ALUSUB);

    // Subtraction reuses the adder as b + ~a + 1
    assign a_op = is_sub ? ~a : a;
    assign sum  = b + a_op + $signed({{(W-1){1'b0}}, is_sub});

    // Each unit's result is gated by its select, then all are OR-merged
    assign add_gated = sum     & {W{is_arith}};
    assign and_gated = (a & b) & {W{s == ALUAND}};
    assign xor_gated = (a ^ b) & {W{s == ALUXOR}};
    assign out       = add_gated | and_gated | xor_gated;

    // Overflow: adder inputs share a sign that the sum does not
    assign ovf = is_arith & (a_op[W-1] == b[W-1]) & (sum[W-1] != b[W-1]);

endmodule

// File: rtl/cond_eval.sv
// Condition evaluator for cmovXX/jXX: maps the flags and a function code to
// the taken/move decision. Also usable by the fetch-stage predictor check.
// Ports: zf, sf, of flags; ifun condition code; cnd outcome.
module cond_eval (
    input  logic       zf,
    input  logic       sf,
    input  logic       of,
    input  logic [3:0] ifun,
    output logic       cnd
);
    logic lt;

    assign lt = sf ^ of;

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            4'h0:    cnd = 1'b1;          // always
            4'h1:    cnd = lt | zf;       // le
            4'h2:    cnd = lt;            // l
            4'h3:    cnd = zf;            // e
            4'h4:    cnd = ~zf;           // ne
            4'h5:    cnd = ~lt;           // ge
            4'h6:    cnd = ~lt & ~zf;     // g
            default: cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU operand/function select,
// condition-code register, cmov/jXX condition, M pipeline register, and the
// combinational e_valE/e_dstE forwarding taps.
// Ports: clk/rst (sync, active-high); E_bubble/M_bubble; d_* decode fields;
// m_stat/W_stat later-stage status; e_valE/e_dstE/e_Cnd forwarding taps;
// ZF/SF/OF flags; M_* memory-stage register outputs.
module execute_stage #(
    parameter int W          = 64,
    parameter int STACK_STEP = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         E_bubble,
    input  logic         M_bubble,
    input  logic [3:0]   d_stat,
    input  logic [3:0]   d_icode,
    input  logic [3:0]   d_ifun,
    input  logic [W-1:0] d_valC,
    input  logic [W-1:0] d_valA,
    input  logic [W-1:0] d_valB,
    input  logic [3:0]   d_dstE,
    input  logic [3:0]   d_dstM,
    input  logic [3:0]   m_stat,
    input  logic [3:0]   W_stat,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic         ZF,
    output logic         SF,
    output logic         OF,
    output logic [3:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);
    import y86_pkg::*;

    localparam logic signed [W-1:0] STEP_POS = W'(STACK_STEP);
    localparam logic signed [W-1:0] STEP_NEG = -STEP_POS;

    e_ctrl_t             ex_ctrl_p0;
    logic signed [W-1:0] ex_valc_p0;
    logic signed [W-1:0] ex_vala_p0;
    logic signed [W-1:0] ex_valb_p0;

    logic signed [W-1:0] alu_a;
    logic signed [W-1:0] alu_b;
    logic        [1:0]   alu_fun;
    logic signed [W-1:0] alu_out;
    logic                alu_ovf;
    logic                set_cc;

    // ---- Stage boundary: decode -> E register ----
    always_ff @(posedge clk) begin
        if (rst || E_bubble) begin
            ex_ctrl_p0 <= E_CTRL_BUBBLE;
            ex_valc_p0 <= '0;
            ex_vala_p0 <= '0;
            ex_valb_p0 <= '0;
        end else begin
            ex_ctrl_p0 <= '{stat: d_stat, icode: d_icode, ifun: d_ifun,
                            dst_e: d_dstE, dst_m: d_dstM};
            ex_valc_p0 <= $signed(d_valC);
            ex_vala_p0 <= $signed(d_valA);
            ex_valb_p0 <= $signed(d_valB);
        end
    end

    always_comb begin
        alu_a = '0;
        case (ex_ctrl_p0.icode)
            IRRMOVQ, IOPQ:             alu_a = ex_vala_p0;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = ex_valc_p0;
            ICALL, IPUSHQ:             alu_a = STEP_NEG;
            IRET, IPOPQ:               alu_a = STEP_POS;
            default:                   alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (ex_ctrl_p0.icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ:
                     alu_b = ex_valb_p0;
            default: alu_b = '0;
        endcase
    end

    assign alu_fun = (ex_ctrl_p0.icode == IOPQ) ? ex_ctrl_p0.ifun[1:0] : ALUADD;

    alu #(.W(W)) u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .s   (alu_fun),
        .out (alu_out),
        .ovf (alu_ovf)
    );

    assign e_valE = alu_out;

    // Flags must not change if an older instruction ahead of us has faulted
    assign set_cc = (ex_ctrl_p0.icode == IOPQ) &&
                    !stat_is_exc(m_stat) && !stat_is_exc(W_stat);

    always_ff @(posedge clk) begin
        if (rst) begin
            ZF <= 1'b1;
            SF <= 1'b0;
            OF <= 1'b0;
        end else if (set_cc) begin
            ZF <= (alu_out == '0);
            SF <= alu_out[W-1];
            OF <= alu_ovf;
        end
    end

    // Condition uses the flags as they stood before this instruction
    cond_eval u_cond_eval (
        .zf   (ZF),
        .sf   (SF),
        .of   (OF),
        .ifun (ex_ctrl_p0.ifun),
        .cnd  (e_Cnd)
    );

    // A cmov that is not taken writes nowhere
    assign e_dstE = ((ex_ctrl_p0.icode == IRRMOVQ) && !e_Cnd) ? RNONE
                                                               : ex_ctrl_p0.dst_e;

    // ---- Stage boundary: E -> M register ----
    always_ff @(posedge clk) begin
        if (rst || M_bubble) begin
            M_stat  <= BUBBLE_STAT;
            M_icode <= BUBBLE_ICODE;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else begin
            M_stat  <= ex_ctrl_p0.stat;
            M_icode <= ex_ctrl_p0.icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= alu_out;
            M_valA  <= ex_vala_p0;
            M_dstE  <= e_dstE;
            M_dstM  <= ex_ctrl_p0.dst_m;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        E_bubble, M_bubble;
    logic [3:0]  d_stat, d_icode, d_ifun, d_dstE, d_dstM, m_stat, W_stat;
    logic [63:0] d_valC, d_valA, d_valB;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic        e_Cnd, ZF, SF, OF, M_Cnd;

    always #5 clk = ~clk;

    execute_stage #(.W(64), .STACK_STEP(8)) dut (
        .clk(clk), .rst(rst), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .d_dstE(d_dstE), .d_dstM(d_dstM), .m_stat(m_stat), .W_stat(W_stat),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .ZF(ZF), .SF(SF), .OF(OF),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    typedef struct {
        logic [3:0]  stat, icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM;
    } instr_t;

    typedef struct {
        logic [3:0]  stat, icode;
        logic        cnd;
        logic [63:0] valE, valA;
        logic [3:0]  dstE, dstM;
        logic        zf, sf, of;
    } expect_t;

    expect_t q[$];
    int      checks = 0;
    int      errors = 0;

    // Reference state: instruction sitting in E and the architectural flags
    instr_t  m_e;
    logic    m_zf, m_sf, m_of;

    function automatic instr_t mk(input logic [3:0] icode, ifun,
                                  input logic [63:0] valC, valA, valB,
                                  input logic [3:0] dstE, dstM);
        instr_t i;
        i.stat = 4'd1; i.icode = icode; i.ifun = ifun;
        i.valC = valC; i.valA = valA; i.valB = valB;
        i.dstE = dstE; i.dstM = dstM;
        return i;
    endfunction

    function automatic instr_t nop_i();
        return mk(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    endfunction

    function automatic logic ref_cond(input logic [3:0] f, input logic zf, sf, of);
        case (f)
            4'h0: return 1'b1;
            4'h1: return (sf != of) || zf;
            4'h2: return (sf != of);
            4'h3: return zf;
            4'h4: return !zf;
            4'h5: return (sf == of);
            4'h6: return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit faulted(input logic [3:0] s);
        return s == 4'd2 || s == 4'd3 || s == 4'd4;
    endfunction

    task automatic check(input string name, input logic [63:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the M register and flags after the
    // coming edge, and queue that prediction.
    task automatic issue(input instr_t d, input bit eb, mb,
                         input logic [3:0] ms, ws, input bit r);
        expect_t     x;
        longint      sa, sb, sr;
        logic [63:0] a, b, res;
        logic        ovf, cnd;
        int          fun;
        rst = r; E_bubble = eb; M_bubble = mb; m_stat = ms; W_stat = ws;
        d_stat = d.stat; d_icode = d.icode; d_ifun = d.ifun;
        d_valC = d.valC; d_valA = d.valA; d_valB = d.valB;
        d_dstE = d.dstE; d_dstM = d.dstM;
        if (r) begin
            x = '{stat: 4'd1, icode: 4'd1, cnd: 1'b0, valE: 64'd0, valA: 64'd0,
                  dstE: 4'hF, dstM: 4'hF, zf: 1'b1, sf: 1'b0, of: 1'b0};
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
            m_e = nop_i();
        end else begin
            cnd = ref_cond(m_e.ifun, m_zf, m_sf, m_of);
            case (m_e.icode)
                4'h2, 4'h6:       a = m_e.valA;
                4'h3, 4'h4, 4'h5: a = m_e.valC;
                4'h8, 4'hA:       a = -64'd8;
                4'h9, 4'hB:       a = 64'd8;
                default:          a = 64'd0;
            endcase
            b   = (m_e.icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB})
                  ? m_e.valB : 64'd0;
            fun = (m_e.icode == 4'h6) ? int'(m_e.ifun[1:0]) : 0;
            sa  = $signed(a); sb = $signed(b);
            case (fun)
                0: res = b + a;
                1: res = b - a;
                2: res = b & a;
                default: res = b ^ a;
            endcase
            sr  = $signed(res);
            ovf = 1'b0;
            if (fun == 0) ovf = (sa >= 0 && sb >= 0 && sr < 0) || (sa < 0 && sb < 0 && sr >= 0);
            if (fun == 1) ovf = (sb >= 0 && sa < 0 && sr < 0) || (sb < 0 && sa >= 0 && sr >= 0);
            if (mb) begin
                x.stat = 4'd1; x.icode = 4'd1; x.cnd = 1'b0; x.valE = 64'd0;
                x.valA = 64'd0; x.dstE = 4'hF; x.dstM = 4'hF;
            end else begin
                x.stat = m_e.stat; x.icode = m_e.icode; x.cnd = cnd; x.valE = res;
                x.valA = m_e.valA;
                x.dstE = (m_e.icode == 4'h2 && !cnd) ? 4'hF : m_e.dstE;
                x.dstM = m_e.dstM;
            end
            if (m_e.icode == 4'h6 && !faulted(ms) && !faulted(ws)) begin
                m_zf = (res == 64'd0); m_sf = res[63]; m_of = ovf;
            end
            x.zf = m_zf; x.sf = m_sf; x.of = m_of;
            m_e = eb ? nop_i() : d;
        end
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic step(input instr_t d);
        issue(d, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0);
    endtask

    // Monitor: M register and flags are compared just after every edge
    initial begin
        expect_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check("M_stat",  {60'd0, M_stat},  {60'd0, x.stat});
                check("M_icode", {60'd0, M_icode}, {60'd0, x.icode});
                check("M_Cnd",   {63'd0, M_Cnd},   {63'd0, x.cnd});
                check("M_valE",  M_valE,           x.valE);
                check("M_valA",  M_valA,           x.valA);
                check("M_dstE",  {60'd0, M_dstE},  {60'd0, x.dstE});
                check("M_dstM",  {60'd0, M_dstM},  {60'd0, x.dstM});
                check("ZF",      {63'd0, ZF},      {63'd0, x.zf});
                check("SF",      {63'd0, SF},      {63'd0, x.sf});
                check("OF",      {63'd0, OF},      {63'd0, x.of});
            end
        end
    end

    initial begin
        instr_t      d;
        logic [63:0] va, vb, vc;
        m_e = nop_i(); m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;

        // Reset for two cycles
        issue(nop_i(), 1'b0, 1'b0, 4'd1, 4'd1, 1'b1);
        issue(nop_i(), 1'b0, 1'b0, 4'd1, 4'd1, 1'b1);

        // sub 5-5 -> zero; add max+max -> overflow
        step(mk(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2, 4'hF));
        step(mk(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h2, 4'hF));
        // 0-1 gives ZF=0 SF=1 OF=0, then cmovle (taken) and cmove (not taken)
        step(mk(4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h4, 4'hF));
        step(mk(4'h2, 4'h1, 64'd0, 64'h55, 64'd0, 4'h3, 4'hF));
        step(mk(4'h2, 4'h3, 64'd0, 64'h66, 64'd0, 4'h3, 4'hF));
        // Stack and displacement arithmetic
        step(mk(4'hA, 4'h0, 64'd0, 64'h11, 64'h100, 4'h4, 4'hF));
        step(mk(4'hB, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4, 4'h5));
        step(mk(4'h4, 4'h0, 64'h20, 64'h77, 64'h100, 4'hF, 4'hF));
        // xor in E while the memory stage reports ADR, with both bubbles
        step(mk(4'h6, 4'h3, 64'd0, 64'h1234, 64'h1234, 4'h6, 4'hF));
        issue(mk(4'h3, 4'h0, 64'h99, 64'd0, 64'd0, 4'h7, 4'hF), 1'b1, 1'b1, 4'd3, 4'd1, 1'b0);
        step(nop_i());
        step(nop_i());

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            va = {$urandom, $urandom};
            vb = ($urandom_range(0, 3) == 0) ? va : {$urandom, $urandom};
            vc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) va = 64'(($urandom_range(0, 3)));
            d = mk(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   vc, va, vb, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 5) == 0) d.icode = 4'h6;
            if ($urandom_range(0, 5) == 0) d.icode = 4'h2;
            d.stat = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'd1;
            issue(d, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 4) == 0) ? 4'($urandom_range(2, 4)) : 4'd1,
                  ($urandom_range(0, 4) == 0) ? 4'($urandom_range(2, 4)) : 4'd1,
                  $urandom_range(0, 49) == 0);
        end

        step(nop_i());
        step(nop_i());
        @(posedge clk);
        #2;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
